instr_register_pipe: RTL and testbench

- Parametrised, pipelined instruction register with per-entry valid/error tracking.
- Accepts (opcode, operand_a, operand_b) into a DEPTH-entry array.
- Result is computed in a registered ALU stage and stored with the instruction; reads are registered with a valid strobe.
- A sequenced bulk-clear engine invalidates all entries.
- Sits between the stimulus generator and the checker as the DUT of the next lab generation.

---
 rtl/instr_register_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_instr_register_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_register_pipe.sv
// rtl/instr_register_pipe.sv - pipelined instruction register with ALU result, valid/error tracking and bulk clear
// Optional feature macro: AUTO_PTR_EN (internal auto-incrementing write pointer replaces write_pointer).

module instr_register_pipe #(
   parameter int OP_W = 32,
   parameter int DEPTH = 32,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int RES_W = 2 * OP_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_en,
   output logic              wr_ready,
   input  logic [3:0]        opcode,
   input  logic [OP_W-1:0]   operand_a,
   input  logic [OP_W-1:0]   operand_b,
   input  logic [ADDR_W-1:0] write_pointer,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] read_pointer,
   output logic              rd_valid,
   output logic              rd_hit,
   output logic [3:0]        rd_opcode,
   output logic [OP_W-1:0]   rd_operand_a,
   output logic [OP_W-1:0]   rd_operand_b,
   output logic [RES_W-1:0]  rd_result,
   output logic              rd_err,
   input  logic              clear,
   output logic              clear_busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              sweep, clear_start, accept;
   logic [ADDR_W-1:0] wr_ptr;

   logic              s1_vld_q;
   logic [3:0]        s1_op_q;
   logic [OP_W-1:0]   s1_a_q, s1_b_q;
   logic [ADDR_W-1:0] s1_ptr_q;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [3:0]        ent_op_q  [DEPTH];
   logic [OP_W-1:0]   ent_a_q   [DEPTH];
   logic [OP_W-1:0]   ent_b_q   [DEPTH];
   logic [RES_W-1:0]  ent_res_q [DEPTH];
   logic              ent_err_q [DEPTH];

   logic signed [RES_W-1:0] a_x, b_x, res_c;
   logic                    err_c;

   logic              fwd, hit_c;
   logic [3:0]        op_c;
   logic [OP_W-1:0]   ra_c, rb_c;
   logic [RES_W-1:0]  rres_c;
   logic              rerr_c;

   assign wr_ready   = (state_q == IDLE);
   assign clear_busy = (state_q == CLEAR);
   assign accept     = load_en & wr_ready;

`ifdef AUTO_PTR_EN
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              unused_wp;

   assign unused_wp = ^write_pointer;
   assign wr_ptr    = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (accept)      ptr_d = ptr_q + ADDR_W'(1);
      if (clear_start) ptr_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end
`else
   assign wr_ptr = write_pointer;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sweep       = 1'b0;
      clear_start = 1'b0;
      case (state_q)
         IDLE: if (clear) begin
            state_d     = CLEAR;
            cnt_d       = '0;
            clear_start = 1'b1;
         end
         CLEAR: begin
            sweep = 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            else                             cnt_d   = cnt_q + ADDR_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands widened to RES_W first so DIV/MOD never overflow and MULT keeps the full product.
   always_comb begin
      a_x   = {{OP_W{s1_a_q[OP_W-1]}}, s1_a_q};
      b_x   = {{OP_W{s1_b_q[OP_W-1]}}, s1_b_q};
      res_c = '0;
      err_c = 1'b0;
      case (s1_op_q)
         4'd0: res_c = '0;
         4'd1: res_c = a_x;
         4'd2: res_c = b_x;
         4'd3: res_c = a_x + b_x;
         4'd4: res_c = a_x - b_x;
         4'd5: res_c = a_x * b_x;
         4'd6: begin
            if (s1_b_q == '0 || (s1_a_q == {1'b1, {(OP_W-1){1'b0}}} && (&s1_b_q))) err_c = 1'b1;
            else res_c = a_x / b_x;
         end
         4'd7: begin
            if (s1_b_q == '0) err_c = 1'b1;
            else              res_c = a_x % b_x;
         end
         default: err_c = 1'b1;
      endcase
   end

   // A write landing on the index being swept in the same cycle loses to the sweep.
   always_comb begin
      valid_d = valid_q;
      if (s1_vld_q) valid_d[s1_ptr_q] = 1'b1;
      if (sweep)    valid_d[cnt_q]    = 1'b0;
   end

   always_comb begin
      fwd    = s1_vld_q && (s1_ptr_q == read_pointer);
      hit_c  = fwd | valid_q[read_pointer];
      op_c   = fwd ? s1_op_q : ent_op_q[read_pointer];
      ra_c   = fwd ? s1_a_q  : ent_a_q[read_pointer];
      rb_c   = fwd ? s1_b_q  : ent_b_q[read_pointer];
      rres_c = fwd ? res_c   : ent_res_q[read_pointer];
      rerr_c = fwd ? err_c   : ent_err_q[read_pointer];
      if (!hit_c) begin
         op_c   = '0;
         ra_c   = '0;
         rb_c   = '0;
         rres_c = '0;
         rerr_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         s1_vld_q <= 1'b0;
         s1_op_q  <= '0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s1_ptr_q <= '0;
         valid_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         s1_vld_q <= accept;
         if (accept) begin
            s1_op_q  <= opcode;
            s1_a_q   <= operand_a;
            s1_b_q   <= operand_b;
            s1_ptr_q <= wr_ptr;
         end
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_op_q[i]  <= '0;
            ent_a_q[i]   <= '0;
            ent_b_q[i]   <= '0;
            ent_res_q[i] <= '0;
            ent_err_q[i] <= 1'b0;
         end
      end else if (s1_vld_q) begin
         ent_op_q[s1_ptr_q]  <= s1_op_q;
         ent_a_q[s1_ptr_q]   <= s1_a_q;
         ent_b_q[s1_ptr_q]   <= s1_b_q;
         ent_res_q[s1_ptr_q] <= res_c;
         ent_err_q[s1_ptr_q] <= err_c;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid     <= 1'b0;
         rd_hit       <= 1'b0;
         rd_opcode    <= '0;
         rd_operand_a <= '0;
         rd_operand_b <= '0;
         rd_result    <= '0;
         rd_err       <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_hit       <= hit_c;
            rd_opcode    <= op_c;
            rd_operand_a <= ra_c;
            rd_operand_b <= rb_c;
            rd_result    <= rres_c;
            rd_err       <= rerr_c;
         end
      end
   end

endmodule

// File: tb/tb_instr_register_pipe.sv
// tb/tb_instr_register_pipe.sv - self-checking bench for instr_register_pipe (vector table, directed sequences, random vs model)
// Build with AUTO_PTR_EN defined to exercise the internal write pointer.

module tb_instr_register_pipe;
   localparam int DEPTH = 32;
   localparam int INT_MIN = int'(32'h8000_0000);

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        load_en = 1'b0, wr_ready, rd_en = 1'b0, clear = 1'b0, clear_busy;
   logic [3:0]  opcode = '0, rd_opcode;
   logic [31:0] operand_a = '0, operand_b = '0, rd_operand_a, rd_operand_b;
   logic [4:0]  write_pointer = '0, read_pointer = '0;
   logic        rd_valid, rd_hit, rd_err;
   logic [63:0] rd_result;

   instr_register_pipe #(.OP_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .wr_ready(wr_ready),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .write_pointer(write_pointer), .rd_en(rd_en), .read_pointer(read_pointer),
      .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_opcode(rd_opcode),
      .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
      .rd_result(rd_result), .rd_err(rd_err), .clear(clear), .clear_busy(clear_busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   // Reference state: entry contents, the one write in flight, clear sweep progress.
   bit          m_valid [DEPTH];
   logic [3:0]  m_op    [DEPTH];
   logic [31:0] m_a     [DEPTH], m_b [DEPTH];
   longint      m_res   [DEPTH];
   bit          m_err   [DEPTH];
   bit          p_vld;
   logic [3:0]  p_op;
   logic [31:0] p_a, p_b;
   int          p_ptr, m_cnt, m_ptr;
   bit          m_busy;
   bit          e_valid, e_hit, e_err;
   logic [3:0]  e_op;
   logic [31:0] e_a, e_b;
   longint      e_res;

   typedef struct {
      logic [3:0] op;
      int         a;
      int         b;
      int         ptr;
      longint     res;
      bit         err;
   } vec_t;
   vec_t tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic void ref_alu(input logic [3:0] op, input int a, input int b,
                                   output longint r, output bit e);
      r = 0;
      e = 1'b0;
      case (op)
         4'd0: r = 0;
         4'd1: r = a;
         4'd2: r = b;
         4'd3: r = longint'(a) + longint'(b);
         4'd4: r = longint'(a) - longint'(b);
         4'd5: r = longint'(a) * longint'(b);
         4'd6: if (b == 0 || (a == INT_MIN && b == -1)) e = 1'b1; else r = longint'(a) / longint'(b);
         4'd7: if (b == 0) e = 1'b1; else r = longint'(a) % longint'(b);
         default: e = 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 0; m_op[i] = 0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0; m_err[i] = 0;
      end
      p_vld = 0; m_busy = 0; m_cnt = 0; m_ptr = 0;
      e_valid = 0; e_hit = 0; e_err = 0; e_op = 0; e_a = 0; e_b = 0; e_res = 0;
   endtask

   task automatic cyc(input bit ld, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int wp, input bit rd, input int rp, input bit clr, output int used);
      bit     acc, cstart, e;
      int     tgt, rpm;
      longint r;
      load_en = ld; opcode = op; operand_a = a; operand_b = b; write_pointer = 5'(wp);
      rd_en = rd; read_pointer = 5'(rp); clear = clr;
      acc    = ld && !m_busy;
      cstart = clr && !m_busy;
`ifdef AUTO_PTR_EN
      tgt = m_ptr;
`else
      tgt = wp % DEPTH;
`endif
      used = tgt;
      rpm  = rp % DEPTH;
      @(posedge clk);
      #1;
      if (p_vld) begin
         ref_alu(p_op, p_a, p_b, r, e);
         m_valid[p_ptr] = 1; m_op[p_ptr] = p_op; m_a[p_ptr] = p_a; m_b[p_ptr] = p_b;
         m_res[p_ptr] = r; m_err[p_ptr] = e;
      end
      e_valid = rd;
      if (rd) begin
         e_hit = m_valid[rpm];
         e_op  = e_hit ? m_op[rpm]  : 4'd0;
         e_a   = e_hit ? m_a[rpm]   : 32'd0;
         e_b   = e_hit ? m_b[rpm]   : 32'd0;
         e_res = e_hit ? m_res[rpm] : 0;
         e_err = e_hit ? m_err[rpm] : 1'b0;
      end
      if (m_busy) begin
         m_valid[m_cnt] = 0;
         m_cnt++;
         if (m_cnt == DEPTH) m_busy = 0;
      end else if (clr) begin
         m_busy = 1;
         m_cnt  = 0;
      end
      if (acc) m_ptr = (m_ptr + 1) % DEPTH;
      if (cstart) m_ptr = 0;
      p_vld = acc; p_op = op; p_a = a; p_b = b; p_ptr = tgt;
      chk("rd_valid", 64'(rd_valid), 64'(e_valid));
      chk("wr_ready", 64'(wr_ready), 64'(!m_busy));
      chk("clear_busy", 64'(clear_busy), 64'(m_busy));
      chk("rd_hit", 64'(rd_hit), 64'(e_hit));
      chk("rd_opcode", 64'(rd_opcode), 64'(e_op));
      chk("rd_operand_a", 64'(rd_operand_a), 64'(e_a));
      chk("rd_operand_b", 64'(rd_operand_b), 64'(e_b));
      chk("rd_result", rd_result, e_res);
      chk("rd_err", 64'(rd_err), 64'(e_err));
   endtask

   task automatic idle();
      int u;
      cyc(0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0, u);
   endtask

   task automatic rd(input int p);
      int u;
      cyc(0, 4'd0, 32'd0, 32'd0, 0, 1, p, 0, u);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      load_en = 0; rd_en = 0; clear = 0;
      #2;
      model_reset();
      chk("reset_rd_valid", 64'(rd_valid), 64'd0);
      chk("reset_wr_ready", 64'(wr_ready), 64'd1);
      chk("reset_clear_busy", 64'(clear_busy), 64'd0);
      chk("reset_rd_result", rd_result, 64'd0);
      reset_n = 1'b1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 5)
         0: pick = 32'd0;
         1: pick = 32'h8000_0000;
         2: pick = 32'hFFFF_FFFF;
         3: pick = 32'($urandom_range(0, 15)) - 32'd8;
         default: pick = $urandom;
      endcase
   endfunction

   initial begin
      int u, n, cnt;
      int us[4];

      tbl[0]  = '{4'd3, 5, -3, 2, 2, 1'b0};
      tbl[1]  = '{4'd5, 32'h7FFF_FFFF, 2, 4, 64'h0000_0000_FFFF_FFFE, 1'b0};
      tbl[2]  = '{4'd6, -7, 2, 5, -3, 1'b0};
      tbl[3]  = '{4'd7, -7, 2, 6, -1, 1'b0};
      tbl[4]  = '{4'd6, 9, 0, 7, 0, 1'b1};
      tbl[5]  = '{4'd12, 1, 1, 8, 0, 1'b1};
      tbl[6]  = '{4'd6, INT_MIN, -1, 9, 0, 1'b1};
      tbl[7]  = '{4'd4, 3, 10, 10, -7, 1'b0};
      tbl[8]  = '{4'd2, 0, -1, 11, -1, 1'b0};
      tbl[9]  = '{4'd5, INT_MIN, INT_MIN, 12, 64'h4000_0000_0000_0000, 1'b0};
      tbl[10] = '{4'd7, 7, -3, 40, 1, 1'b0};
      tbl[11] = '{4'd0, 5, 6, 13, 0, 1'b0};
      tbl[12] = '{4'd7, INT_MIN, -1, 14, 0, 1'b0};

      @(posedge clk);
      #1;
      do_reset();

      foreach (tbl[i]) begin
         cyc(1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ptr, 0, 0, 0, u);
         idle();
         idle();
         rd(u);
         chk($sformatf("tbl%0d_hit", i), 64'(rd_hit), 64'd1);
         chk($sformatf("tbl%0d_op", i), 64'(rd_opcode), 64'(tbl[i].op));
         chk($sformatf("tbl%0d_res", i), rd_result, tbl[i].res);
         chk($sformatf("tbl%0d_err", i), 64'(rd_err), 64'(tbl[i].err));
      end

      for (int i = 0; i < 4; i++) cyc(1, 4'd1, 32'(10 + i), 32'd0, i, 0, 0, 0, us[i]);
      idle();
      idle();
      for (int i = 0; i < 4; i++) begin
         rd(us[i]);
         chk($sformatf("b2b%0d_res", i), rd_result, 64'(10 + i));
      end

      cyc(1, 4'd1, 32'd99, 32'd0, 3, 0, 0, 0, u);
      rd(u);
      chk("fwd_hit", 64'(rd_hit), 64'd1);
      chk("fwd_res", rd_result, 64'd99);
      idle();
      chk("hold_valid", 64'(rd_valid), 64'd0);
      chk("hold_res", rd_result, 64'd99);

      for (int i = 0; i < DEPTH; i++) cyc(1, 4'd1, $urandom, 32'd1, i, 0, 0, 0, u);
      cyc(0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 1, u);
      cnt = 0;
      n = 0;
      while (clear_busy && n < DEPTH + 4) begin
         if (!wr_ready) cnt++;
         n++;
         cyc(1, 4'd1, 32'd5, 32'd0, n, 0, 0, 1, u);
      end
      chk("clear_len", 64'(cnt), 64'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         rd(i);
         chk($sformatf("clr%0d_hit", i), 64'(rd_hit), 64'd0);
         chk($sformatf("clr%0d_res", i), rd_result, 64'd0);
      end

      cyc(1, 4'd1, 32'd55, 32'd0, 6, 0, 0, 1, u);
      for (int i = 0; i < DEPTH + 2; i++) idle();
      rd(u);
      chk("inflight_clr_hit", 64'(rd_hit), 64'd0);

      cyc(1, 4'd1, 32'd42, 32'd0, 9, 0, 0, 0, u);
      do_reset();
      rd(u);
      chk("rst_inflight_hit", 64'(rd_hit), 64'd0);

`ifdef AUTO_PTR_EN
      for (int i = 0; i <= DEPTH; i++) cyc(1, 4'd1, 32'(i), 32'd0, 7, 0, 0, 0, u);
      idle();
      rd(0);
      chk("auto_wrap_res", rd_result, 64'(DEPTH));
`endif

      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 3) != 0,
             ($urandom % 10 < 8) ? 4'($urandom % 8) : 4'($urandom % 16),
             pick(), pick(), $urandom % 8,
             ($urandom % 2) == 1, $urandom % 8,
             ($urandom % 50) == 0, u);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
